// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, ALU opcodes, operand-2 source
// select and the ID/EX latched-field bundle.
package cpu_types_pkg;

    localparam int CPU_WORD_W = 32;
    localparam int CPU_REG_W  = 5;

    typedef logic [CPU_WORD_W-1:0] word_t;
    typedef logic [CPU_REG_W-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'b0000,
        ALU_SRL  = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_SRA  = 4'b1010
    } aluop_t;

    typedef enum logic [1:0] {
        ALUSRC_REG   = 2'b00,
        ALUSRC_IMM   = 2'b01,
        ALUSRC_SHAMT = 2'b10
    } alusrc_t;

    typedef struct packed {
        logic       valid;
        regbits_t   rs;
        regbits_t   rt;
        word_t      rdat1;
        word_t      rdat2;
        word_t      imm;
        logic [4:0] shamt;
        alusrc_t    alusrc;
        aluop_t     alucode;
        logic       wen;
        regbits_t   wsel;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Combinational RAW bypass for one source register: EX/MEM beats MEM/WB,
// register 0 is never bypassed.
module forward_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = CPU_WORD_W,
    parameter int REG_W  = CPU_REG_W
) (
    input  logic [REG_W-1:0]  src,
    input  logic [WORD_W-1:0] dat,
    input  logic              exm_wen,
    input  logic [REG_W-1:0]  exm_wsel,
    input  logic [WORD_W-1:0] exm_wdat,
    input  logic              mwb_wen,
    input  logic [REG_W-1:0]  mwb_wsel,
    input  logic [WORD_W-1:0] mwb_wdat,
    output logic [WORD_W-1:0] fwd
);

    logic src_nz;
    logic exm_hit;
    logic mwb_hit;

    assign src_nz  = (src != '0);
    assign exm_hit = exm_wen && (exm_wsel == src) && src_nz;
    assign mwb_hit = mwb_wen && (mwb_wsel == src) && src_nz;

    always_comb begin
        fwd = dat;
        if (exm_hit) begin
            fwd = exm_wdat;
        end else if (mwb_hit) begin
            fwd = mwb_wdat;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with EX/MEM and MEM/WB operand bypass.
// Bypass and stall-refresh are built only when ID_EX_FORWARD_EN is defined.
module id_ex_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = CPU_WORD_W,
    parameter int REG_W  = CPU_REG_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [WORD_W-1:0] id_rdat1,
    input  logic [WORD_W-1:0] id_rdat2,
    input  logic [WORD_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [1:0]        id_alusrc,
    input  logic [3:0]        id_alucode,
    input  logic              id_wen,
    input  logic [REG_W-1:0]  id_wsel,
    input  logic              exm_wen,
    input  logic [REG_W-1:0]  exm_wsel,
    input  logic [WORD_W-1:0] exm_wdat,
    input  logic              mwb_wen,
    input  logic [REG_W-1:0]  mwb_wsel,
    input  logic [WORD_W-1:0] mwb_wdat,
    output logic              ex_valid,
    output logic [WORD_W-1:0] ex_oprnd1,
    output logic [WORD_W-1:0] ex_oprnd2,
    output logic [3:0]        ex_alucode,
    output logic [WORD_W-1:0] ex_store_dat,
    output logic              ex_wen,
    output logic [REG_W-1:0]  ex_wsel
);

    id_ex_t id_p0;
    id_ex_t ex_p1;
    word_t  fwd_rs;
    word_t  fwd_rt;

    // Operand 2 source; the unused 2'b11 encoding falls back to the register path.
    function automatic word_t sel_oprnd2(input alusrc_t src, input word_t reg_dat,
                                         input word_t imm, input logic [4:0] shamt);
        case (src)
            ALUSRC_IMM:   sel_oprnd2 = imm;
            ALUSRC_SHAMT: sel_oprnd2 = {{(CPU_WORD_W-5){1'b0}}, shamt};
            default:      sel_oprnd2 = reg_dat;
        endcase
    endfunction

    always_comb begin
        id_p0         = '0;
        id_p0.valid   = id_valid;
        id_p0.rs      = id_rs;
        id_p0.rt      = id_rt;
        id_p0.rdat1   = id_rdat1;
        id_p0.rdat2   = id_rdat2;
        id_p0.imm     = id_imm;
        id_p0.shamt   = id_shamt;
        id_p0.alusrc  = alusrc_t'(id_alusrc);
        id_p0.alucode = aluop_t'(id_alucode);
        id_p0.wen     = id_wen;
        id_p0.wsel    = id_wsel;
    end

    // ---- p0 -> p1: decode fields latched into the EX slot ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_p1 <= '0;
        end else if (flush) begin
            ex_p1.valid <= 1'b0;
            ex_p1.wen   <= 1'b0;
        end else if (stall) begin
`ifdef ID_EX_FORWARD_EN
            // Capture bypassed values so a producer retiring during the stall is not lost.
            ex_p1.rdat1 <= fwd_rs;
            ex_p1.rdat2 <= fwd_rt;
`endif
        end else begin
            ex_p1 <= id_p0;
        end
    end

`ifdef ID_EX_FORWARD_EN
    forward_unit #(.WORD_W(CPU_WORD_W), .REG_W(CPU_REG_W)) u_fwd_rs (
        .src      (ex_p1.rs),
        .dat      (ex_p1.rdat1),
        .exm_wen  (exm_wen),
        .exm_wsel (exm_wsel),
        .exm_wdat (exm_wdat),
        .mwb_wen  (mwb_wen),
        .mwb_wsel (mwb_wsel),
        .mwb_wdat (mwb_wdat),
        .fwd      (fwd_rs)
    );

    forward_unit #(.WORD_W(CPU_WORD_W), .REG_W(CPU_REG_W)) u_fwd_rt (
        .src      (ex_p1.rt),
        .dat      (ex_p1.rdat2),
        .exm_wen  (exm_wen),
        .exm_wsel (exm_wsel),
        .exm_wdat (exm_wdat),
        .mwb_wen  (mwb_wen),
        .mwb_wsel (mwb_wsel),
        .mwb_wdat (mwb_wdat),
        .fwd      (fwd_rt)
    );
`else
    logic unused_fwd;

    assign fwd_rs     = ex_p1.rdat1;
    assign fwd_rt     = ex_p1.rdat2;
    assign unused_fwd = ^{exm_wen, exm_wsel, exm_wdat, mwb_wen, mwb_wsel, mwb_wdat,
                          ex_p1.rs, ex_p1.rt};
`endif

    // ---- p1: EX slot outputs toward the ALU and EX/MEM ----
    assign ex_valid     = ex_p1.valid;
    assign ex_wen       = ex_p1.wen & ex_p1.valid;
    assign ex_wsel      = ex_p1.wsel;
    assign ex_alucode   = ex_p1.alucode;
    assign ex_oprnd1    = fwd_rs;
    assign ex_store_dat = fwd_rt;
    assign ex_oprnd2    = sel_oprnd2(ex_p1.alusrc, fwd_rt, ex_p1.imm, ex_p1.shamt);

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations follow ID_EX_FORWARD_EN when defined.
module tb_id_ex_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stall, flush, id_valid, id_wen;
    logic [4:0]  id_rs, id_rt, id_wsel, id_shamt;
    logic [31:0] id_rdat1, id_rdat2, id_imm;
    logic [1:0]  id_alusrc;
    logic [3:0]  id_alucode;
    logic        exm_wen, mwb_wen;
    logic [4:0]  exm_wsel, mwb_wsel;
    logic [31:0] exm_wdat, mwb_wdat;
    logic        ex_valid, ex_wen;
    logic [31:0] ex_oprnd1, ex_oprnd2, ex_store_dat;
    logic [3:0]  ex_alucode;
    logic [4:0]  ex_wsel;

    typedef struct {
        logic        ctl_only;
        logic        valid;
        logic        wen;
        logic [4:0]  wsel;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  alu;
        logic [31:0] store;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_ex_stage dut (
        .CLK(CLK), .RST(RST), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_alusrc(id_alusrc), .id_alucode(id_alucode),
        .id_wen(id_wen), .id_wsel(id_wsel),
        .exm_wen(exm_wen), .exm_wsel(exm_wsel), .exm_wdat(exm_wdat),
        .mwb_wen(mwb_wen), .mwb_wsel(mwb_wsel), .mwb_wdat(mwb_wdat),
        .ex_valid(ex_valid), .ex_oprnd1(ex_oprnd1), .ex_oprnd2(ex_oprnd2),
        .ex_alucode(ex_alucode), .ex_store_dat(ex_store_dat),
        .ex_wen(ex_wen), .ex_wsel(ex_wsel)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic ctl_only, input logic valid, input logic wen,
                            input logic [4:0] wsel, input logic [31:0] op1,
                            input logic [31:0] op2, input logic [3:0] alu,
                            input logic [31:0] store);
        exp_t e;
        e.ctl_only = ctl_only; e.valid = valid; e.wen = wen; e.wsel = wsel;
        e.op1 = op1; e.op2 = op2; e.alu = alu; e.store = store;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string name);
        exp_t e;
        check_eq({name, "/sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check_eq({name, "/valid"}, 32'(ex_valid), 32'(e.valid));
        check_eq({name, "/wen"},   32'(ex_wen),   32'(e.wen));
        if (!e.ctl_only) begin
            check_eq({name, "/wsel"},  32'(ex_wsel),    32'(e.wsel));
            check_eq({name, "/op1"},   ex_oprnd1,       e.op1);
            check_eq({name, "/op2"},   ex_oprnd2,       e.op2);
            check_eq({name, "/alu"},   32'(ex_alucode), 32'(e.alu));
            check_eq({name, "/store"}, ex_store_dat,    e.store);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [31:0] d1,
                          input logic [4:0] rt, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [4:0] sh, input logic [1:0] src, input logic [3:0] alu,
                          input logic w, input logic [4:0] ws);
        id_valid = v; id_rs = rs; id_rdat1 = d1; id_rt = rt; id_rdat2 = d2; id_imm = imm;
        id_shamt = sh; id_alusrc = src; id_alucode = alu; id_wen = w; id_wsel = ws;
    endtask

    initial begin
        logic [31:0] r1, r2, ri, e2;
        logic [4:0]  rs, rt, sh, ws;
        logic [1:0]  src;
        logic [3:0]  alu;
        logic        v, w;

        RST = 1'b1; stall = 1'b0; flush = 1'b0;
        set_id(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 2'd0, 4'd0, 1'b0, 5'd0);
        exm_wen = 1'b0; exm_wsel = 5'd0; exm_wdat = 32'd0;
        mwb_wen = 1'b0; mwb_wsel = 5'd0; mwb_wdat = 32'd0;
        cyc(); cyc();
        push_exp(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 32'd0);
        sb_check("reset_init");
        RST = 1'b0;

        // Plain load, 1-cycle latency
        set_id(1'b1, 5'd3, 32'd12345, 5'd4, 32'd6789, 32'h0, 5'd0, 2'b00, 4'b0010, 1'b1, 5'd9);
        push_exp(1'b0, 1'b1, 1'b1, 5'd9, 32'd12345, 32'd6789, 4'b0010, 32'd6789);
        cyc();
        sb_check("load");

        // Double producer hit on rs, then EX/MEM drops out
        set_id(1'b1, 5'd5, 32'h11, 5'd6, 32'h22, 32'h0, 5'd0, 2'b00, 4'b0011, 1'b1, 5'd10);
        cyc();
        exm_wen = 1'b1; exm_wsel = 5'd5; exm_wdat = 32'hAAAA0000;
        mwb_wen = 1'b1; mwb_wsel = 5'd5; mwb_wdat = 32'h55555555;
        #1;
        push_exp(1'b0, 1'b1, 1'b1, 5'd10, FWD ? 32'hAAAA0000 : 32'h11, 32'h22, 4'b0011, 32'h22);
        sb_check("dbl_hit");
        exm_wen = 1'b0;
        #1;
        push_exp(1'b0, 1'b1, 1'b1, 5'd10, FWD ? 32'h55555555 : 32'h11, 32'h22, 4'b0011, 32'h22);
        sb_check("mwb_hit");

        // Register 0 never forwarded
        set_id(1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 32'h0, 5'd0, 2'b00, 4'b0010, 1'b1, 5'd1);
        exm_wen = 1'b1; exm_wsel = 5'd0; exm_wdat = 32'hFFFFFFFF;
        mwb_wen = 1'b1; mwb_wsel = 5'd0; mwb_wdat = 32'h77;
        push_exp(1'b0, 1'b1, 1'b1, 5'd1, 32'd0, 32'd0, 4'b0010, 32'd0);
        cyc();
        sb_check("reg0");
        exm_wen = 1'b0; mwb_wen = 1'b0;

        // Stall refresh: producer retires while EX is stalled
        set_id(1'b1, 5'd1, 32'h5, 5'd7, 32'h99, 32'h0, 5'd0, 2'b00, 4'b0100, 1'b1, 5'd12);
        cyc();
        mwb_wen = 1'b1; mwb_wsel = 5'd7; mwb_wdat = 32'h1234; stall = 1'b1;
        set_id(1'b0, 5'd2, 32'hDEAD, 5'd3, 32'hBEEF, 32'h0, 5'd0, 2'b01, 4'b0001, 1'b0, 5'd3);
        #1;
        e2 = FWD ? 32'h1234 : 32'h99;
        push_exp(1'b0, 1'b1, 1'b1, 5'd12, 32'h5, e2, 4'b0100, e2);
        sb_check("stall_pre");
        cyc();
        mwb_wen = 1'b0;
        #1;
        push_exp(1'b0, 1'b1, 1'b1, 5'd12, 32'h5, e2, 4'b0100, e2);
        sb_check("stall_held");
        stall = 1'b0;

        // Flush wins over stall
        set_id(1'b1, 5'd2, 32'h1, 5'd3, 32'h2, 32'h0, 5'd0, 2'b00, 4'b0010, 1'b1, 5'd4);
        flush = 1'b1; stall = 1'b1;
        push_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 32'd0);
        cyc();
        sb_check("flush_stall");
        flush = 1'b0; stall = 1'b0;

        // Operand-2 source selection
        set_id(1'b1, 5'd2, 32'h1, 5'd8, 32'h4444, 32'h123, 5'd10, 2'b10, 4'b0000, 1'b1, 5'd5);
        push_exp(1'b0, 1'b1, 1'b1, 5'd5, 32'h1, 32'd10, 4'b0000, 32'h4444);
        cyc();
        sb_check("shamt");
        set_id(1'b1, 5'd2, 32'h1, 5'd8, 32'h4444, 32'hFFFFFF80, 5'd31, 2'b01, 4'b0010, 1'b1, 5'd5);
        push_exp(1'b0, 1'b1, 1'b1, 5'd5, 32'h1, 32'hFFFFFF80, 4'b0010, 32'h4444);
        cyc();
        sb_check("imm");
        set_id(1'b1, 5'd2, 32'h1, 5'd8, 32'h4444, 32'hFFFFFF80, 5'd31, 2'b11, 4'b0010, 1'b1, 5'd5);
        push_exp(1'b0, 1'b1, 1'b1, 5'd5, 32'h1, 32'h4444, 4'b0010, 32'h4444);
        cyc();
        sb_check("src11");

        // Invalid slot masks wen
        set_id(1'b0, 5'd2, 32'h1, 5'd8, 32'h4444, 32'h0, 5'd0, 2'b00, 4'b0010, 1'b1, 5'd6);
        push_exp(1'b0, 1'b0, 1'b0, 5'd6, 32'h1, 32'h4444, 4'b0010, 32'h4444);
        cyc();
        sb_check("inval_wen");

        // Random loads with no producers active
        for (int i = 0; i < 10; i++) begin
            v = 1'($urandom); w = 1'($urandom);
            rs = 5'($urandom); rt = 5'($urandom); ws = 5'($urandom); sh = 5'($urandom);
            r1 = $urandom; r2 = $urandom; ri = $urandom;
            src = 2'($urandom_range(0, 3)); alu = 4'($urandom_range(0, 10));
            set_id(v, rs, r1, rt, r2, ri, sh, src, alu, w, ws);
            e2 = (src == 2'b01) ? ri : (src == 2'b10) ? {27'd0, sh} : r2;
            push_exp(1'b0, v, v & w, ws, r1, e2, alu, r2);
            cyc();
            sb_check($sformatf("rand%0d", i));
        end

        // Asynchronous reset mid-stall with busy inputs
        set_id(1'b1, 5'd9, 32'hCAFE, 5'd9, 32'hF00D, 32'h1, 5'd3, 2'b01, 4'b0111, 1'b1, 5'd9);
        cyc();
        exm_wen = 1'b1; exm_wsel = 5'd9; exm_wdat = 32'h13579BDF;
        mwb_wen = 1'b1; mwb_wsel = 5'd9; mwb_wdat = 32'h2468ACE0;
        stall = 1'b1; flush = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        push_exp(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 32'd0);
        sb_check("reset_async");
        cyc();
        push_exp(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 32'd0);
        sb_check("reset_hold");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU.
- Latches decoded operands, immediate, shift amount, alucode and destination from decode each cycle.
- Resolves RAW data hazards by forwarding from EX/MEM and MEM/WB.
- Drives oprnd1, oprnd2 and alucode into the ALU via control_hazard_alu_if, plus store data and writeback tags to EX/MEM.

Parameters:
- WORD_W, 32, datapath width.
- REG_W, 5, register index width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- stall  in  1  hold current contents (refresh with forwarded data).
- flush  in  1  insert bubble.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs, id_rt  in  REG_W  source register indices.
- id_rdat1, id_rdat2  in  WORD_W  register file read data.
- id_imm  in  WORD_W  already-extended immediate.
- id_shamt  in  5  shift amount.
- id_alusrc  in  2  alusrc_t: 00 REG, 01 IMM, 10 SHAMT.
- id_alucode  in  4  aluop_t.
- id_wen  in  1  instruction writes a register.
- id_wsel  in  REG_W  destination index.
- exm_wen, exm_wsel, exm_wdat  in  1/REG_W/WORD_W  EX/MEM producer.
- mwb_wen, mwb_wsel, mwb_wdat  in  1/REG_W/WORD_W  MEM/WB producer.
- ex_valid  out  1  EX slot valid.
- ex_oprnd1, ex_oprnd2  out  WORD_W  to ALU oprnd1/oprnd2.
- ex_alucode  out  4  to ALU alucode.
- ex_store_dat  out  WORD_W  forwarded rt value, for stores.
- ex_wen  out  1  equals latched wen AND ex_valid.
- ex_wsel  out  REG_W  latched destination.

Behaviour:
- Reset: all latched fields 0. ex_valid=0, ex_wen=0, ex_alucode=ALU_SLL (0000). Operands and store data are 0.
- Clock-edge priority: RST > flush > stall > load.
- flush: ex_valid<=0 and latched wen<=0; other fields are don't-care but held.
- load (no stall, no flush): every id_* field is captured, with 1-cycle latency from decode to the ALU inputs.
- Forward select per source s in {rs, rt}, computed combinationally from latched values:
  - EX/MEM hit when exm_wen && exm_wsel==s && s!=0.
  - Otherwise MEM/WB hit under the same rule.
  - Otherwise the latched rdat.
  - EX/MEM has priority when both producers hit.
  - Register 0 is never forwarded and always reads the latched value.
- Operands:
  - ex_oprnd1 = fwd(rs).
  - ex_oprnd2 = fwd(rt) for REG; id_imm for IMM; zero-extended shamt for SHAMT.
  - alusrc 11 is treated as REG.
- ex_store_dat = fwd(rt), regardless of alusrc.
- stall (no flush): latched rdat1/rdat2 are overwritten with fwd(rs)/fwd(rt); all other fields are held. This keeps operands correct if the producer retires while EX is stalled.
- Forwarding is applied even when ex_valid=0; the outputs are harmless because ex_wen=0.
- Load-use hazards are not detected here. The upstream hazard unit must stall decode one cycle.
- Reset asserted mid-stall clears everything immediately (asynchronous); no forwarded value survives.

Optional Feature:
- ID_EX_FORWARD_EN.
- Defined: forwarding and stall-refresh as above.
- Undefined: no forwarding. Operands come straight from the latched rdat; stall holds all fields unchanged; exm_*/mwb_* inputs are ignored. Software or the hazard unit must insert NOPs.

Decomposition:
- cpu_types_pkg: add alusrc_t (2-bit enum REG/IMM/SHAMT) and the packed struct id_ex_t holding the latched fields. Reuse existing word_t, regbits_t, aluop_t.
- Sub-module: forward_unit, purely combinational. It takes one source index, the latched data and both producers, and returns the selected word. It is instantiated twice, for rs and rt.

Test Plan:
1. Reset with RST=1 mid-run, all inputs nonzero -> ex_valid=0, ex_wen=0, ex_oprnd1/2=0, ex_alucode=0000 within the same cycle.
2. Plain load: rs=3, rdat1=12345, rt=4, rdat2=6789, ADD, REG -> next cycle ex_oprnd1=12345, ex_oprnd2=6789, ex_alucode=0010.
3. Double hit: latched rs=5, exm_wsel=5 wdat=0xAAAA0000, mwb_wsel=5 wdat=0x55555555, both wen=1 -> ex_oprnd1=0xAAAA0000. Then drop exm_wen -> ex_oprnd1=0x55555555.
4. Register 0: rs=0, rdat1=0, exm_wsel=0 wen=1 wdat=0xFFFFFFFF -> ex_oprnd1=0.
5. Stall refresh: rt=7, mwb_wsel=7 wdat=0x1234, stall=1 for one cycle. Next cycle mwb_wen=0, stall=0 -> ex_oprnd2 and ex_store_dat both still equal 0x1234.
6. Flush vs. stall: flush=1 and stall=1 together with id_valid=1, id_wen=1 -> ex_valid=0, ex_wen=0. Separately, SLL with alusrc=SHAMT and shamt=10 -> ex_oprnd2=10.
